// File: rtl/countdown_timer_if.sv
// Bundles the control inputs and status outputs of the HH:MM:SS countdown
// timer. The controller side (master) drives tick/load/start/pause/ack; the
// timer (slave) drives the packed-BCD count and status flags.
interface countdown_timer_if;
  logic       tick;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       start;
  logic       pause;
  logic       ack;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       running;
  logic       expired;
  logic       alarm;
  logic       load_err;

  modport master (
    output tick, load, load_hh, load_mm, load_ss, start, pause, ack,
    input  hh, mm, ss, running, expired, alarm, load_err
  );

  modport slave (
    input  tick, load, load_hh, load_mm, load_ss, start, pause, ack,
    output hh, mm, ss, running, expired, alarm, load_err
  );
endinterface

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer in packed BCD, decremented once per 1 Hz tick.
// States IDLE/RUN/PAUSED/DONE; DONE holds the alarm for ALARM_LEN ticks or
// until ack. Input priority in one cycle: load > pause > start > tick.
// Optional build macro AUTO_RELOAD_EN: on the tick that would reach
// 00:00:00 the stored preset is reloaded, the timer keeps running and the
// alarm never asserts.
module countdown_timer #(
  parameter int MAX_HOURS = 23,
  parameter int ALARM_LEN = 10
) (
  input  logic clk,
  input  logic rst,
  countdown_timer_if.slave bus
);

  localparam int ACW = $clog2(ALARM_LEN + 1);
  localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_LEN - 1);
  localparam logic [7:0] MAX_HH = 8'(MAX_HOURS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t         state_reg, state_next;
  logic [23:0]    count_reg, count_next;
  logic [23:0]    preset_reg, preset_next;
  logic [ACW-1:0] alarm_cnt_reg, alarm_cnt_next;
  logic           expired_reg, expired_next;
  logic           load_err_reg, load_err_next;

  logic [23:0]    load_val;
  logic           load_ok;
  logic [8:0]     ss_dec;
  logic [8:0]     mm_dec;
  logic [7:0]     hh_dec;
  logic [23:0]    count_dec;

  // Decrement a 00..59 BCD field; returns {borrow, new value}.
  function automatic logic [8:0] dec_sexa(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    logic       b;
    t = v[7:4];
    o = v[3:0];
    b = 1'b0;
    if (o == 4'd0) begin
      o = 4'd9;
      if (t == 4'd0) begin
        t = 4'd5;
        b = 1'b1;
      end else begin
        t = t - 4'd1;
      end
    end else begin
      o = o - 4'd1;
    end
    return {b, t, o};
  endfunction

  // Decrement the hours field; only called when hours is non-zero, since a
  // running count is never 00:00:00.
  function automatic logic [7:0] dec_hours(input logic [7:0] v);
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // A load value must be proper BCD with minutes/seconds below 60 and the
  // hours value within MAX_HOURS.
  function automatic logic valid_load(input logic [7:0] h, input logic [7:0] m,
                                      input logic [7:0] s);
    logic [7:0] hval;
    hval = ({4'd0, h[7:4]} * 8'd10) + {4'd0, h[3:0]};
    return (s[3:0] <= 4'd9) && (m[3:0] <= 4'd9) && (h[3:0] <= 4'd9) &&
           (s[7:4] <= 4'd5) && (m[7:4] <= 4'd5) && (h[7:4] <= 4'd9) &&
           (hval <= MAX_HH);
  endfunction

  // Borrow chain seconds -> minutes -> hours.
  assign ss_dec    = dec_sexa(count_reg[7:0]);
  assign mm_dec    = ss_dec[8] ? dec_sexa(count_reg[15:8]) : {1'b0, count_reg[15:8]};
  assign hh_dec    = mm_dec[8] ? dec_hours(count_reg[23:16]) : count_reg[23:16];
  assign count_dec = {hh_dec, mm_dec[7:0], ss_dec[7:0]};

  assign load_val  = {bus.load_hh, bus.load_mm, bus.load_ss};
  assign load_ok   = valid_load(bus.load_hh, bus.load_mm, bus.load_ss);

  // State register and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_reg     <= 24'h000000;
      preset_reg    <= 24'h000000;
      alarm_cnt_reg <= '0;
      expired_reg   <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      preset_reg    <= preset_next;
      alarm_cnt_reg <= alarm_cnt_next;
      expired_reg   <= expired_next;
      load_err_reg  <= load_err_next;
    end
  end

  // Next-state and next-datapath logic in priority order load > pause > start > tick.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    preset_next    = preset_reg;
    alarm_cnt_next = alarm_cnt_reg;
    expired_next   = 1'b0;
    load_err_next  = 1'b0;

    if (bus.load && (state_reg != RUN)) begin
      if (load_ok) begin
        count_next  = load_val;
        preset_next = load_val;
        state_next  = IDLE;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (bus.pause && (state_reg == RUN)) begin
      state_next = PAUSED;
    end else if (bus.start && ((state_reg == IDLE) || (state_reg == PAUSED)) &&
                 (count_reg != 24'h000000)) begin
      state_next = RUN;
    end else if (state_reg == DONE) begin
      if (bus.ack) begin
        state_next = IDLE;
      end else if (bus.tick) begin
        alarm_cnt_next = alarm_cnt_reg + 1'b1;
        if (alarm_cnt_reg == ALARM_LAST)
          state_next = IDLE;
      end
    end else if (bus.tick && (state_reg == RUN)) begin
      if (count_dec == 24'h000000) begin
        expired_next = 1'b1;
`ifdef AUTO_RELOAD_EN
        count_next   = preset_reg;
`else
        count_next     = count_dec;
        state_next     = DONE;
        alarm_cnt_next = '0;
`endif
      end else begin
        count_next = count_dec;
      end
    end
  end

  assign bus.hh       = count_reg[23:16];
  assign bus.mm       = count_reg[15:8];
  assign bus.ss       = count_reg[7:0];
  assign bus.running  = (state_reg == RUN);
  assign bus.alarm    = (state_reg == DONE);
  assign bus.expired  = expired_reg;
  assign bus.load_err = load_err_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer. Observed word layout:
// {hh, mm, ss, running, expired, alarm, load_err}.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [27:0] obs;
  logic [27:0] expv;

  countdown_timer_if bus();

  countdown_timer #(.MAX_HOURS(23), .ALARM_LEN(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.hh, bus.mm, bus.ss, bus.running, bus.expired, bus.alarm, bus.load_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.tick = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.ack = 1'b0;
    bus.load_hh = 8'h00; bus.load_mm = 8'h00; bus.load_ss = 8'h00;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.load = 1'b1; bus.load_hh = h; bus.load_mm = m; bus.load_ss = s;
    step();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  task automatic do_pause();
    bus.pause = 1'b1; step(); bus.pause = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    bus.tick = 1'b1;
    repeat (n) step();
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.tick = 1'b1; bus.start = 1'b1;
    rst = 1'b0;
    step();
    step();
    expv = 28'h0;
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL reset_state: got %h want %h", obs, expv); end
    else $display("ok   reset_state            %h", obs);
    clear_inputs();
    rst = 1'b1;
  endtask

  task automatic test_minute_countdown();
    apply_reset();
    do_load(8'h00, 8'h01, 8'h00);
    expv = {24'h000100, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL minute_load: got %h want %h", obs, expv); end
    else $display("ok   minute_load            %h", obs);
    do_start();
    expv = {24'h000100, 4'b1000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL minute_start: got %h want %h", obs, expv); end
    else $display("ok   minute_start           %h", obs);
    do_ticks(1);
    expv = {24'h000059, 4'b1000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL minute_first_tick: got %h want %h", obs, expv); end
    else $display("ok   minute_first_tick      %h", obs);
    do_ticks(58);
    expv = {24'h000001, 4'b1000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL minute_one_left: got %h want %h", obs, expv); end
    else $display("ok   minute_one_left        %h", obs);
    do_ticks(1);
    expv = {24'h000000, 4'b0110}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL minute_expiry: got %h want %h", obs, expv); end
    else $display("ok   minute_expiry          %h", obs);
    step();
    expv = {24'h000000, 4'b0010}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL expired_one_cycle: got %h want %h", obs, expv); end
    else $display("ok   expired_one_cycle      %h", obs);
    do_ticks(9);
    expv = {24'h000000, 4'b0010}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL alarm_after_9: got %h want %h", obs, expv); end
    else $display("ok   alarm_after_9          %h", obs);
    do_ticks(1);
    expv = {24'h000000, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL alarm_after_10: got %h want %h", obs, expv); end
    else $display("ok   alarm_after_10         %h", obs);
    do_start();
    expv = {24'h000000, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL start_at_zero: got %h want %h", obs, expv); end
    else $display("ok   start_at_zero          %h", obs);
  endtask

  task automatic test_hour_borrow();
    logic [23:0] t;
    apply_reset();
    do_load(8'h01, 8'h00, 8'h00);
    do_start();
    do_ticks(1);
    expv = {24'h005959, 4'b1000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL hour_borrow: got %h want %h", obs, expv); end
    else $display("ok   hour_borrow            %h", obs);
    t = obs[27:4];
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (t[i*4 +: 4] > 4'd9) begin
        miscompares++;
        $display("FAIL bcd_nibble_%0d: got %h want 0..9", i, t[i*4 +: 4]);
      end
    end
    do_ticks(1);
    expv = {24'h005958, 4'b1000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL hour_borrow_next: got %h want %h", obs, expv); end
    else $display("ok   hour_borrow_next       %h", obs);
  endtask

  task automatic test_pause_resume();
    apply_reset();
    do_load(8'h00, 8'h00, 8'h05);
    do_start();
    do_ticks(2);
    do_pause();
    expv = {24'h000003, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL pause_enter: got %h want %h", obs, expv); end
    else $display("ok   pause_enter            %h", obs);
    do_ticks(3);
    expv = {24'h000003, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL pause_hold: got %h want %h", obs, expv); end
    else $display("ok   pause_hold             %h", obs);
    do_start();
    do_ticks(3);
`ifdef AUTO_RELOAD_EN
    expv = {24'h000005, 4'b1100};
`else
    expv = {24'h000000, 4'b0110};
`endif
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL resume_expiry: got %h want %h", obs, expv); end
    else $display("ok   resume_expiry          %h", obs);
  endtask

  task automatic test_invalid_load();
    apply_reset();
    do_load(8'h00, 8'h00, 8'h05);
    do_load(8'h00, 8'h60, 8'h00);
    expv = {24'h000005, 4'b0001}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL bad_mm: got %h want %h", obs, expv); end
    else $display("ok   bad_mm                 %h", obs);
    step();
    expv = {24'h000005, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL load_err_pulse: got %h want %h", obs, expv); end
    else $display("ok   load_err_pulse         %h", obs);
    do_load(8'h00, 8'h00, 8'h0A);
    expv = {24'h000005, 4'b0001}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL bad_ss: got %h want %h", obs, expv); end
    else $display("ok   bad_ss                 %h", obs);
    do_load(8'h24, 8'h00, 8'h00);
    expv = {24'h000005, 4'b0001}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL bad_hh: got %h want %h", obs, expv); end
    else $display("ok   bad_hh                 %h", obs);
    do_load(8'h23, 8'h59, 8'h59);
    expv = {24'h235959, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL max_load: got %h want %h", obs, expv); end
    else $display("ok   max_load               %h", obs);
    do_start();
    do_load(8'h01, 8'h00, 8'h00);
    expv = {24'h235959, 4'b1000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL load_in_run: got %h want %h", obs, expv); end
    else $display("ok   load_in_run            %h", obs);
  endtask

  task automatic test_same_cycle();
    apply_reset();
    do_load(8'h00, 8'h00, 8'h10);
    do_start();
    bus.pause = 1'b1; bus.tick = 1'b1;
    step();
    clear_inputs();
    expv = {24'h000010, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL pause_tick: got %h want %h", obs, expv); end
    else $display("ok   pause_tick             %h", obs);
    apply_reset();
    bus.start = 1'b1;
    do_load(8'h00, 8'h00, 8'h20);
    clear_inputs();
    expv = {24'h000020, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL load_start: got %h want %h", obs, expv); end
    else $display("ok   load_start             %h", obs);
`ifndef AUTO_RELOAD_EN
    do_load(8'h00, 8'h00, 8'h01);
    do_start();
    do_ticks(1);
    bus.ack = 1'b1; bus.tick = 1'b1;
    step();
    clear_inputs();
    expv = {24'h000000, 4'b0000}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL ack_tick: got %h want %h", obs, expv); end
    else $display("ok   ack_tick               %h", obs);
    do_load(8'h00, 8'h00, 8'h01);
    do_start();
    do_ticks(1);
    expv = {24'h000000, 4'b0110}; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL alarm_again: got %h want %h", obs, expv); end
    else $display("ok   alarm_again            %h", obs);
`else
    do_load(8'h00, 8'h00, 8'h03);
    do_start();
    do_ticks(1);
`endif
    rst = 1'b0;
    step();
    rst = 1'b1;
    expv = 28'h0; vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL reset_mid: got %h want %h", obs, expv); end
    else $display("ok   reset_mid              %h", obs);
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [7:0] want_ss [6];
    logic       want_exp [6];
    want_ss  = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02};
    want_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    do_load(8'h00, 8'h00, 8'h02);
    do_start();
    for (int i = 0; i < 6; i++) begin
      do_ticks(1);
      expv = {16'h0000, want_ss[i], 1'b1, want_exp[i], 2'b00};
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL auto_reload_%0d: got %h want %h", i, obs, expv); end
      else $display("ok   auto_reload_%0d          %h", i, obs);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
`ifndef AUTO_RELOAD_EN
    test_minute_countdown();
`else
    test_auto_reload();
`endif
    test_hour_borrow();
    test_pause_resume();
    test_invalid_load();
    test_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
